codec_sample_buffer: RTL and testbench
======================================

# codec_sample_buffer

Stereo playback buffer that sits directly upstream of the ADAU1761 codec wrapper. It accepts left/right sample pairs from the audio generator through a valid/ready handshake and stores them in a FIFO. On each codec `new_sample` strobe it presents the next pair on `hphone_l`/`hphone_r`. It decouples the producer's bursty timing from the codec's fixed 48 kHz frame rate and counts underruns.

## Interface
- `WIDTH`, 24, sample width per channel.
- `DEPTH`, 16, FIFO depth in stereo pairs; power of two, ≥ 2.
- `CNT_W`, log2(DEPTH)+1, width of `level`.

- `clk_100`  in  1  system clock, 100 MHz.
- `reset`  in  1  asynchronous, active-low reset.
- `flush`  in  1  synchronous clear of buffered samples.
- `in_valid`  in  1  producer has a pair on `in_l`/`in_r`.
- `in_ready`  out  1  buffer can accept a pair this cycle.
- `in_l`, `in_r`  in  WIDTH  producer samples, signed two's complement.
- `new_sample`  in  1  codec frame strobe, asynchronous to `clk_100`.
- `hphone_l`, `hphone_r`  out  WIDTH  samples to codec, registered.
- `sample_tick`  out  1  one-cycle pulse when `hphone_*` are updated from the FIFO.
- `underrun`  out  1  one-cycle pulse when a strobe finds the FIFO empty.
- `underrun_count`  out  16  saturating count of underruns.
- `level`  out  CNT_W  number of pairs held, 0..DEPTH.

## Operation
- Push: `in_valid & in_ready & ~flush` writes {`in_l`,`in_r`} at the write pointer and increments it, wrapping modulo DEPTH.
- Strobe detect: `new_sample` passes through a 2-FF synchronizer and a third register. `pop_req = s2 & ~s3`, so each rising edge gives one request regardless of pulse width.
- Pop when `pop_req` and level>0:
  - `hphone_*` load the head pair.
  - Read pointer advances, wrapping.
  - `sample_tick` pulses.
- Pop when `pop_req` and level==0:
  - `hphone_*` hold their previous value. There is no muting.
  - `underrun` pulses.
  - `underrun_count` increments and saturates at 0xFFFF.
- Pop decisions use the pre-edge level. If a push and a `pop_req` occur together at level 0, the pop underruns and the push is stored (level becomes 1).
- Simultaneous push and pop with level>0: level is unchanged; both pointers advance.
- Flush:
  - Pointers and level are cleared. Any push in the same cycle is dropped.
  - A `pop_req` in the flush cycle is treated as level 0 and counts as an underrun.
  - `hphone_*` and `underrun_count` are unchanged.
- `in_ready` is registered as `level_next < DEPTH`, so it is never high while the FIFO is full. It is forced to 0 in the cycle after a flush is asserted? No: after a flush `in_ready` is 1.
- Reset (async, any time):
  - Pointers, level, and the synchronizer clear.
  - `hphone_*` = 0, `in_ready` = 0, `sample_tick` = 0, `underrun` = 0, `underrun_count` = 0, `level` = 0.
  - A reset in mid-stream discards all buffered data.

## Timing
- `in_ready` rises on the first `clk_100` edge after `reset` deasserts.
- Strobe latency: `new_sample` sampled high at edge k gives `s1` at k, `s2` at k+1, and the pop at edge k+2. `hphone_*`, `sample_tick`, `underrun`, and `level` change at edge k+2.
- A push at edge j is visible in `level` after edge j. It is poppable by a `pop_req` evaluated at edge j+1.
- Full: a push at level DEPTH−1 makes `in_ready` 0 after the same edge, unless a pop occurs on that edge.
- Throughput: one push per cycle. Pops are at most one per codec frame, about 2083 cycles.

## Structure
- Shared codec package/header holds `SAMPLE_WIDTH = 24`, `CODEC_FS = 48000`, and the stereo pair packing {left, right}.
- Sub-module `stereo_fifo`: dual-pointer storage with push, pop, flush, level, full, and empty.
- Synchronizer, edge detect, underrun logic, and output registers stay in `codec_sample_buffer`.

## Test plan
- Reset, then push pairs (1,−1),(2,−2),(3,−3), then pulse `new_sample` three times. Required: `hphone` shows each pair in order, each 3 cycles after its strobe. `level` goes 3→0. Three `sample_tick` pulses.
- Hold `in_valid` high for 20 pairs with DEPTH=16 and no strobes. Required: exactly 16 accepted, `in_ready`=0 from the cycle after the 16th push, `level`=16.
- Empty FIFO with `hphone` = (5,−5), pulse `new_sample`. Required: `hphone` holds (5,−5), `underrun` pulses once, `underrun_count`=1, no `sample_tick`.
- Hold `new_sample` high for 10 cycles with 4 pairs buffered. Required: exactly one pop, `level`=3.
- Load 8 pairs, then assert `flush` in the same cycle as a push and a `pop_req`. Required: `level`=0, push dropped, `underrun_count` +1, `hphone` unchanged.
- Assert `reset` while `level`=5 in the middle of a stream. Required: all outputs go to their reset values immediately. After release, a strobe underruns.

Source files
------------

// File: rtl/codec_sample_buffer_pkg.sv
// Shared codec constants for the playback path.
// Stereo pairs are packed {left, right}: left in the upper half of a pair word.
package codec_sample_buffer_pkg;

  localparam int unsigned SAMPLE_WIDTH = 24;
  localparam int unsigned CODEC_FS     = 48000;
  localparam int unsigned CLK_HZ       = 100_000_000;
  // Nominal clk_100 cycles between codec frame strobes.
  localparam int unsigned FRAME_CYCLES = CLK_HZ / CODEC_FS;

endpackage

// File: rtl/codec_sample_buffer_stereo_fifo.sv
// Dual-pointer FIFO of packed stereo pairs with push, pop, flush and occupancy.
// Depth must be a power of two so the pointers wrap naturally.
module codec_sample_buffer_stereo_fifo #(
  parameter int unsigned Width = 24,
  parameter int unsigned Depth = 16,
  parameter int unsigned CntW  = $clog2(Depth) + 1
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 push_i,
  input  logic                 pop_i,
  input  logic                 flush_i,
  input  logic [2*Width-1:0]   wr_data_i,
  output logic [2*Width-1:0]   rd_data_o,
  output logic [CntW-1:0]      level_o,
  output logic [CntW-1:0]      level_next_o,
  output logic                 full_o,
  output logic                 empty_o
);

  localparam int unsigned      PtrW     = $clog2(Depth);
  localparam logic [CntW-1:0]  DepthCnt = CntW'(Depth);

  logic [PtrW-1:0]    wptr_q, wptr_d;
  logic [PtrW-1:0]    rptr_q, rptr_d;
  logic [CntW-1:0]    level_q, level_d;
  logic [2*Width-1:0] mem_q [Depth];
  logic               wr_en, rd_en;

  assign full_o  = (level_q == DepthCnt);
  assign empty_o = (level_q == '0);

  // Flush wins over both ports: nothing is written or consumed that cycle.
  assign wr_en = push_i & ~flush_i & ~full_o;
  assign rd_en = pop_i & ~flush_i & ~empty_o;

  assign rd_data_o    = mem_q[rptr_q];
  assign level_o      = level_q;
  assign level_next_o = level_d;

  // Next pointer and occupancy state.
  always_comb begin
    wptr_d  = wptr_q;
    rptr_d  = rptr_q;
    level_d = level_q;
    if (flush_i) begin
      wptr_d  = '0;
      rptr_d  = '0;
      level_d = '0;
    end else begin
      if (wr_en) wptr_d = wptr_q + 1'b1;
      if (rd_en) rptr_d = rptr_q + 1'b1;
      level_d = level_q + CntW'(wr_en) - CntW'(rd_en);
    end
  end

  // Pointer and level registers.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      level_q <= '0;
    end else begin
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      level_q <= level_d;
    end
  end

  // Sample storage; contents are don't-care until written.
  always_ff @(posedge clk_i) begin
    if (wr_en) mem_q[wptr_q] <= wr_data_i;
  end

endmodule

// File: rtl/codec_sample_buffer.sv
// Stereo playback buffer feeding the codec wrapper: accepts producer pairs,
// releases one pair per codec frame strobe and counts underruns.
module codec_sample_buffer
  import codec_sample_buffer_pkg::*;
#(
  parameter int unsigned WIDTH = SAMPLE_WIDTH,
  parameter int unsigned DEPTH = 16,
  parameter int unsigned CNT_W = $clog2(DEPTH) + 1
) (
  input  logic             clk_100,
  input  logic             reset,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_l,
  input  logic [WIDTH-1:0] in_r,
  input  logic             new_sample,
  output logic [WIDTH-1:0] hphone_l,
  output logic [WIDTH-1:0] hphone_r,
  output logic             sample_tick,
  output logic             underrun,
  output logic [15:0]      underrun_count,
  output logic [CNT_W-1:0] level
);

  localparam logic [CNT_W-1:0] DepthCnt = CNT_W'(DEPTH);

  logic               s1_q, s2_q, s3_q;
  logic               pop_req, push, pop_ok, underrun_ev;
  logic               in_ready_q, sample_tick_q, underrun_q;
  logic [WIDTH-1:0]   hphone_l_q, hphone_r_q;
  logic [15:0]        underrun_cnt_q;
  logic [2*WIDTH-1:0] head;
  logic [CNT_W-1:0]   fifo_level, fifo_level_next;
  logic               fifo_full, fifo_empty;

  // One request per rising edge of the resynchronised strobe, whatever its width.
  assign pop_req = s2_q & ~s3_q;

  assign push        = in_valid & in_ready_q & ~fifo_full & ~flush;
  // Decisions use the pre-edge level; a flush cycle behaves as empty.
  assign pop_ok      = pop_req & ~flush & ~fifo_empty;
  assign underrun_ev = pop_req & (flush | fifo_empty);

  codec_sample_buffer_stereo_fifo #(
    .Width (WIDTH),
    .Depth (DEPTH),
    .CntW  (CNT_W)
  ) u_fifo (
    .clk_i        (clk_100),
    .rst_ni       (reset),
    .push_i       (push),
    .pop_i        (pop_ok),
    .flush_i      (flush),
    .wr_data_i    ({in_l, in_r}),
    .rd_data_o    (head),
    .level_o      (fifo_level),
    .level_next_o (fifo_level_next),
    .full_o       (fifo_full),
    .empty_o      (fifo_empty)
  );

  // Two-flop synchroniser plus edge-detect stage for the codec strobe.
  always_ff @(posedge clk_100 or negedge reset) begin
    if (!reset) begin
      s1_q <= 1'b0;
      s2_q <= 1'b0;
      s3_q <= 1'b0;
    end else begin
      s1_q <= new_sample;
      s2_q <= s1_q;
      s3_q <= s2_q;
    end
  end

  // Registered outputs: codec samples, event pulses, underrun counter, ready.
  always_ff @(posedge clk_100 or negedge reset) begin
    if (!reset) begin
      hphone_l_q     <= '0;
      hphone_r_q     <= '0;
      sample_tick_q  <= 1'b0;
      underrun_q     <= 1'b0;
      underrun_cnt_q <= '0;
      in_ready_q     <= 1'b0;
    end else begin
      sample_tick_q <= pop_ok;
      underrun_q    <= underrun_ev;
      // On underrun the last pair is held rather than muted.
      if (pop_ok) begin
        hphone_l_q <= head[2*WIDTH-1:WIDTH];
        hphone_r_q <= head[WIDTH-1:0];
      end
      if (underrun_ev && underrun_cnt_q != 16'hFFFF) begin
        underrun_cnt_q <= underrun_cnt_q + 16'd1;
      end
      in_ready_q <= (fifo_level_next < DepthCnt);
    end
  end

  assign in_ready       = in_ready_q;
  assign hphone_l       = hphone_l_q;
  assign hphone_r       = hphone_r_q;
  assign sample_tick    = sample_tick_q;
  assign underrun       = underrun_q;
  assign underrun_count = underrun_cnt_q;
  assign level          = fifo_level;

endmodule

// File: tb/tb_codec_sample_buffer.sv
// Scoreboard bench for codec_sample_buffer: strobes queue the expected codec
// event, a negedge monitor pops and compares whenever tick or underrun fires.
module tb_codec_sample_buffer;
  import codec_sample_buffer_pkg::*;

  localparam int unsigned W  = SAMPLE_WIDTH;
  localparam int unsigned D  = 16;
  localparam int unsigned CW = 5;

  logic          clk_100 = 1'b0;
  logic          reset;
  logic          flush;
  logic          in_valid;
  logic          in_ready;
  logic [W-1:0]  in_l, in_r;
  logic          new_sample;
  logic [W-1:0]  hphone_l, hphone_r;
  logic          sample_tick;
  logic          underrun;
  logic [15:0]   underrun_count;
  logic [CW-1:0] level;

  codec_sample_buffer #(
    .WIDTH (W),
    .DEPTH (D),
    .CNT_W (CW)
  ) dut (
    .clk_100        (clk_100),
    .reset          (reset),
    .flush          (flush),
    .in_valid       (in_valid),
    .in_ready       (in_ready),
    .in_l           (in_l),
    .in_r           (in_r),
    .new_sample     (new_sample),
    .hphone_l       (hphone_l),
    .hphone_r       (hphone_r),
    .sample_tick    (sample_tick),
    .underrun       (underrun),
    .underrun_count (underrun_count),
    .level          (level)
  );

  always #5 clk_100 = ~clk_100;

  typedef struct {
    bit          tick;
    logic [W-1:0] l;
    logic [W-1:0] r;
    logic [15:0] cnt;
    int          due;
  } ev_t;

  ev_t sb[$];
  int  total = 0;
  int  bad   = 0;
  int  cyc   = 0;
  int  accepted;

  always @(posedge clk_100) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: every codec-side event must match the oldest expectation.
  always @(negedge clk_100) begin
    ev_t e;
    if (reset && (sample_tick || underrun)) begin
      if (sb.size() == 0) begin
        check("event_expected", 32'(sb.size()), 32'd1);
      end else begin
        e = sb.pop_front();
        check("event_kind", {30'b0, sample_tick, underrun}, {30'b0, e.tick, ~e.tick});
        check("event_cycle", 32'(cyc), 32'(e.due));
        check("hphone_l", 32'(hphone_l), 32'(e.l));
        check("hphone_r", 32'(hphone_r), 32'(e.r));
        check("event_underrun_count", 32'(underrun_count), 32'(e.cnt));
      end
    end
  end

  // Tasks start and end just after a falling edge.
  task automatic push(input int l, input int r);
    check("push_ready", 32'(in_ready), 32'd1);
    in_valid = 1'b1;
    in_l     = W'(l);
    in_r     = W'(r);
    @(negedge clk_100);
    in_valid = 1'b0;
  endtask

  task automatic strobe(input bit tick, input int l, input int r, input int cnt,
                        input int hold);
    sb.push_back('{tick: tick, l: W'(l), r: W'(r), cnt: 16'(cnt), due: cyc + 3});
    new_sample = 1'b1;
    repeat (hold) @(negedge clk_100);
    new_sample = 1'b0;
    repeat (5) @(negedge clk_100);
    check("strobe_served", 32'(sb.size()), 32'd0);
  endtask

  initial begin
    repeat (20 * FRAME_CYCLES) @(posedge clk_100);
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset      = 1'b0;
    flush      = 1'b0;
    in_valid   = 1'b0;
    in_l       = '0;
    in_r       = '0;
    new_sample = 1'b0;
    repeat (3) @(negedge clk_100);

    // Reset state.
    check("rst_hphone_l", 32'(hphone_l), 32'd0);
    check("rst_hphone_r", 32'(hphone_r), 32'd0);
    check("rst_in_ready", 32'(in_ready), 32'd0);
    check("rst_level", 32'(level), 32'd0);
    check("rst_underrun_count", 32'(underrun_count), 32'd0);
    check("rst_pulses", {30'b0, sample_tick, underrun}, 32'd0);
    reset = 1'b1;
    @(negedge clk_100);
    check("in_ready_after_reset", 32'(in_ready), 32'd1);

    // Three pairs out in order.
    push(1, -1);
    push(2, -2);
    push(3, -3);
    check("level_three", 32'(level), 32'd3);
    strobe(1'b1, 1, -1, 0, 1);
    check("level_two", 32'(level), 32'd2);
    strobe(1'b1, 2, -2, 0, 1);
    strobe(1'b1, 3, -3, 0, 1);
    check("level_drained", 32'(level), 32'd0);

    // Underrun holds last pair.
    push(5, -5);
    strobe(1'b1, 5, -5, 0, 1);
    strobe(1'b0, 5, -5, 1, 1);
    check("underrun_count_one", 32'(underrun_count), 32'd1);
    check("hold_hphone_l", 32'(hphone_l), 32'(W'(5)));

    // Fill to capacity with in_valid held for 20 cycles.
    accepted = 0;
    in_valid = 1'b1;
    for (int i = 0; i < 20; i++) begin
      in_l = W'(100 + accepted);
      in_r = W'(-(100 + accepted));
      if (in_ready) accepted++;
      @(negedge clk_100);
    end
    in_valid = 1'b0;
    check("full_accepted", 32'(accepted), 32'(D));
    check("full_in_ready", 32'(in_ready), 32'd0);
    check("full_level", 32'(level), 32'(D));

    // Drain through pointer wrap.
    for (int i = 0; i < 16; i++) strobe(1'b1, 100 + i, -(100 + i), 1, 1);
    check("wrap_level", 32'(level), 32'd0);

    // Long strobe pulse gives one pop.
    push(7, -7);
    push(8, -8);
    push(9, -9);
    push(10, -10);
    check("level_four", 32'(level), 32'd4);
    strobe(1'b1, 7, -7, 1, 10);
    check("long_strobe_level", 32'(level), 32'd3);

    // Flush coincident with push and pop request.
    for (int i = 11; i <= 15; i++) push(i, -i);
    check("level_eight", 32'(level), 32'd8);
    sb.push_back('{tick: 1'b0, l: W'(7), r: W'(-7), cnt: 16'd2, due: cyc + 3});
    new_sample = 1'b1;
    @(negedge clk_100);
    new_sample = 1'b0;
    @(negedge clk_100);
    flush    = 1'b1;
    in_valid = 1'b1;
    in_l     = W'(99);
    in_r     = W'(-99);
    @(negedge clk_100);
    flush    = 1'b0;
    in_valid = 1'b0;
    check("flush_level", 32'(level), 32'd0);
    check("flush_in_ready", 32'(in_ready), 32'd1);
    check("flush_underrun_count", 32'(underrun_count), 32'd2);
    check("flush_hphone_l", 32'(hphone_l), 32'(W'(7)));
    repeat (3) @(negedge clk_100);
    check("flush_event_seen", 32'(sb.size()), 32'd0);
    push(20, -20);
    check("post_flush_level", 32'(level), 32'd1);
    strobe(1'b1, 20, -20, 2, 1);

    // Asynchronous reset mid-stream.
    for (int i = 30; i < 35; i++) push(i, -i);
    check("level_five", 32'(level), 32'd5);
    in_valid = 1'b1;
    in_l     = W'(35);
    in_r     = W'(-35);
    #2 reset = 1'b0;
    #1;
    check("async_hphone_l", 32'(hphone_l), 32'd0);
    check("async_hphone_r", 32'(hphone_r), 32'd0);
    check("async_in_ready", 32'(in_ready), 32'd0);
    check("async_level", 32'(level), 32'd0);
    check("async_underrun_count", 32'(underrun_count), 32'd0);
    check("async_pulses", {30'b0, sample_tick, underrun}, 32'd0);
    @(negedge clk_100);
    in_valid = 1'b0;
    @(negedge clk_100);
    reset = 1'b1;
    @(negedge clk_100);
    check("rerelease_in_ready", 32'(in_ready), 32'd1);
    check("rerelease_level", 32'(level), 32'd0);
    strobe(1'b0, 0, 0, 1, 1);

    check("scoreboard_empty", 32'(sb.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
